// File: rtl/hex7seg_pkg.sv
// hex7seg_pkg: pin map, segment table and blank pattern for hex_to_7_seg
package hex7seg_pkg;
  localparam int unsigned IO_LATCH    = 0;
  localparam int unsigned IO_BLANK    = 1;
  localparam int unsigned IO_DATA_LSB = 2;
  localparam int unsigned IO_DATA_MSB = 5;
  localparam int unsigned IO_DP_IN    = 6;
  localparam int unsigned IO_RSVD     = 7;
  localparam int unsigned IO_SEG_MSB  = 6;
  localparam int unsigned IO_DP_OUT   = 7;
  localparam logic [7:0] BLANK_PATTERN = 8'h00;
  // entry n occupies bits [7n+6:7n], segments g..a
  localparam logic [111:0] SEG_ROM = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    return SEG_ROM[7*d +: 7];
  endfunction
endpackage

// File: rtl/hex7seg_sync2.sv
// hex7seg_sync2: two-flop synchronizer with async active-low reset
module hex7seg_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/hex_to_7_seg.sv
// hex_to_7_seg: latched hex-to-seven-segment driver; HEX7SEG_ACTIVE_LOW_EN inverts io_out
module hex_to_7_seg
  import hex7seg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);
`ifdef HEX7SEG_ACTIVE_LOW_EN
  localparam logic [7:0] OUT_MASK = 8'hFF;
`else
  localparam logic [7:0] OUT_MASK = 8'h00;
`endif
  logic latch_s, blank_s, latch_q, rise, valid, dp;
  logic [3:0] digit;
  logic [7:0] disp;
  logic unused_rsvd;
  assign unused_rsvd = io_in[IO_RSVD];
  hex7seg_sync2 u_latch_sync (.clk(clk), .rst_n(rst_n), .d(io_in[IO_LATCH]), .q(latch_s));
  hex7seg_sync2 u_blank_sync (.clk(clk), .rst_n(rst_n), .d(io_in[IO_BLANK]), .q(blank_s));
  assign rise = latch_s & ~latch_q;
  // data and decimal_in are sampled raw; the host holds them stable across the sync delay
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      latch_q <= 1'b0;
      valid   <= 1'b0;
      dp      <= 1'b0;
      digit   <= 4'h0;
    end else begin
      latch_q <= latch_s;
      if (rise) begin
        valid <= 1'b1;
        dp    <= io_in[IO_DP_IN];
        digit <= io_in[IO_DATA_MSB:IO_DATA_LSB];
      end
    end
  assign disp = (blank_s || !valid) ? BLANK_PATTERN : {dp, hex_to_seg(digit)};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) io_out <= BLANK_PATTERN ^ OUT_MASK;
    else io_out <= disp ^ OUT_MASK;
endmodule

// File: tb/tb_hex_to_7_seg.sv
// tb_hex_to_7_seg: randomized and directed checks of hex_to_7_seg against a display model
module tb_hex_to_7_seg;
`ifdef HEX7SEG_ACTIVE_LOW_EN
  localparam logic [7:0] MASK = 8'hFF;
`else
  localparam logic [7:0] MASK = 8'h00;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic latch = 1'b0, blank = 1'b0, dpi = 1'b0, rsv = 1'b0;
  logic [3:0] data = 4'h0;
  logic [7:0] io_in, io_out;
  int checks = 0, failures = 0;
  logic [7:0] seg_ref [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  logic m_valid = 1'b0, m_dp = 1'b0;
  logic [3:0] m_digit = 4'h0;
  assign io_in = {rsv, dpi, data, blank, latch};
  always #5 clk = ~clk;
  hex_to_7_seg dut (.clk(clk), .rst_n(rst_n), .io_in(io_in), .io_out(io_out));
  function automatic logic [7:0] model();
    return ((blank || !m_valid) ? 8'h00 : (seg_ref[m_digit] | {m_dp, 7'h00})) ^ MASK;
  endfunction
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: io_out=%02h expected=%02h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_latch(input logic [3:0] d, input logic p);
    data = d;
    dpi = p;
    latch = 1'b1;
    tick(4);
    m_valid = 1'b1;
    m_digit = d;
    m_dp = p;
    latch = 1'b0;
    tick(2);
  endtask
  initial begin
    data = 4'hA;
    dpi = 1'b1;
    rsv = 1'b1;
    blank = 1'b0;
    tick(3);
    check("reset", io_out, 8'h00 ^ MASK);
    rst_n = 1'b1;
    tick(5);
    check("post_reset", io_out, 8'h00 ^ MASK);
    for (int i = 0; i < 16; i++) begin
      do_latch(4'(i), 1'b0);
      check($sformatf("sweep_%0h", i), io_out, model());
    end
    // exact latch latency: three edges still old, fourth shows new
    data = 4'h8;
    latch = 1'b1;
    tick(3);
    check("latch_lat_old", io_out, model());
    tick(1);
    m_digit = 4'h8;
    check("latch_lat_new", io_out, 8'h7F ^ MASK);
    latch = 1'b0;
    tick(2);
    do_latch(4'h3, 1'b1);
    check("dp_on", io_out, 8'hCF ^ MASK);
    data = 4'h5;
    tick(6);
    check("dp_hold", io_out, 8'hCF ^ MASK);
    do_latch(4'hA, 1'b0);
    check("show_A", io_out, 8'h77 ^ MASK);
    blank = 1'b1;
    tick(2);
    check("blank_lat_old", io_out, 8'h77 ^ MASK);
    tick(1);
    check("blank_on", io_out, 8'h00 ^ MASK);
    do_latch(4'h1, 1'b1);
    check("blank_latch", io_out, 8'h00 ^ MASK);
    blank = 1'b0;
    tick(2);
    check("unblank_lat_old", io_out, 8'h00 ^ MASK);
    tick(1);
    check("unblank", io_out, 8'h86 ^ MASK);
    data = 4'h2;
    dpi = 1'b0;
    latch = 1'b1;
    tick(4);
    data = 4'h7;
    tick(6);
    check("level_hold", io_out, 8'h5B ^ MASK);
    latch = 1'b0;
    tick(3);
    do_latch(4'h7, 1'b0);
    check("relatch", io_out, 8'h07 ^ MASK);
    for (int i = 0; i < 40; i++) begin
      rsv = 1'($urandom);
      blank = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) begin
        data = 4'($urandom);
        dpi = 1'($urandom);
        tick(6);
      end else do_latch(4'($urandom), 1'($urandom));
      check($sformatf("rand_%0d", i), io_out, model());
    end
    blank = 1'b0;
    do_latch(4'h5, 1'b0);
    check("pre_async", io_out, 8'h6D ^ MASK);
    #2 rst_n = 1'b0;
    #1 check("async_reset", io_out, 8'h00 ^ MASK);
    m_valid = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(6);
    check("reset_lost", io_out, model());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
